datagen_stream: RTL
===================

Name: datagen_stream

Overview:
Parametrised successor to the fixed 8-bit sample-and-stream generator. It captures a frame of generated samples (counter, LFSR or constant pattern, with optional decimation) into an internal buffer. It then emits the frame as an AXI4-Stream master toward the DMA S2MM path. Frames repeat after a programmable delay, or stop after one frame in one-shot mode. A sticky done flag and a frame counter are provided for the PS driver.

Parameters:
DATA_W, 32, sample/tdata width; legal 8..32.
DEPTH_LOG2, 8, log2 of buffer depth; max frame = 2**DEPTH_LOG2 samples.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
en_ctr  in  1  advances the counter/LFSR source by one step per cycle.
en_sample  in  1  run enable for the frame machine.
mode  in  2  source select: 0 counter, 1 LFSR, 2 pattern, 3 treated as 0.
pattern  in  DATA_W  constant value used in mode 2.
one_shot  in  1  1 = return to IDLE after one frame.
frame_size  in  DEPTH_LOG2+1  samples per frame.
decim  in  8  capture one sample every decim+1 cycles.
delay  in  32  DELAY dwell; state lasts delay+1 cycles.
clr  in  1  clears done.
done  out  1  sticky frame-complete flag.
frame_cnt  out  16  completed-frame count.
debug_state  out  3  current state encoding.
m_axis_tvalid  out  1  AXI-S valid.
m_axis_tready  in  1  AXI-S ready.
m_axis_tlast  out  1  AXI-S last.
m_axis_tdata  out  DATA_W  AXI-S data.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) sets every register to its reset value on that edge, including mid-frame:
  - state=IDLE, ctr=0, lfsr=1, all pointers and counters 0.
  - done=0, frame_cnt=0, tvalid=0, tlast=0, tdata=0.
- Source:
  - ctr is a DATA_W counter that wraps.
  - lfsr is a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1. Its output is the low DATA_W bits. If lfsr ever reads 0, it reloads 1.
  - Both advance only when en_ctr=1.
  - The captured value is the source register value before that cycle's update.
- frame_len is latched on the DELAY->SAMPLE transition: 0 clamps to 1, values above 2**DEPTH_LOG2 clamp to 2**DEPTH_LOG2. frame_size changes mid-frame have no effect.
- States:
  - IDLE: if en_sample, go to DELAY.
  - DELAY: delay_ctr counts from 0. If en_sample=0, go to IDLE. Else if delay_ctr==delay, go to SAMPLE.
  - SAMPLE: decim_ctr counts 0..decim and wraps. A write occurs when decim_ctr==0, writing buffer[wr_ptr] and incrementing wr_ptr. The write at wr_ptr==frame_len-1 moves to LOAD. If en_sample=0, go to IDLE and discard the partial frame (done unchanged).
  - LOAD: one cycle to read buffer[0] into the output register; then go to STREAM.
  - STREAM:
    - tvalid=1; tdata is the registered RAM output.
    - On a handshake (tvalid&tready), rd_ptr increments and the next word is read, so a new word is presented on every handshake cycle with zero bubbles.
    - Without a handshake, tdata and tlast hold stable.
    - tlast=1 exactly when rd_ptr==frame_len-1.
    - The handshake with tlast ends the frame: frame_cnt increments (wraps at 16 bits) and done is set. Next state is IDLE if one_shot=1 or en_sample=0, else DELAY.
    - en_sample deasserting mid-STREAM never truncates a frame.
- done: a set event and clr in the same cycle leave done=1 (set wins). clr alone clears done on the next edge.
- tvalid is 0 in every state except STREAM. tvalid never drops before its handshake.

Decomposition:
- Package datagen_pkg:
  - state encodings S_IDLE=0, S_DELAY=1, S_SAMPLE=2, S_LOAD=3, S_STREAM=4.
  - mode constants MODE_CTR, MODE_LFSR, MODE_PAT.
  - LFSR polynomial constant 32'h80200003.
- Sub-module sample_ram: simple dual-port RAM, DATA_W x 2**DEPTH_LOG2, one write port, one registered read port, no reset on storage.

Test Plan:
- mode=0, en_ctr=1, frame_size=4, decim=0, delay=2, tready=1, one_shot=1 -> 3 DELAY cycles, then 4 consecutive beats with contiguous ctr values; tlast on beat 4; done=1; frame_cnt=1; state returns to IDLE.
- Same setup with tready toggling 1,0,0,1 -> tdata/tlast stable during stalls; all 4 beats delivered in order with no duplicates or loss.
- decim=2, frame_size=3, mode=0 -> captured values differ by 3 (e.g. 5,8,11).
- frame_size=0 then frame_size=2**DEPTH_LOG2+5 -> frames of 1 beat and of 256 beats respectively; wr_ptr/rd_ptr wrap without corruption.
- one_shot=0, en_sample held -> back-to-back frames; frame_cnt increments each frame; clr asserted on the same cycle as a tlast handshake -> done remains 1.
- en_sample dropped mid-SAMPLE -> IDLE with no stream output. rst asserted mid-STREAM -> tvalid=0 and all outputs at reset values on the next edge.

Source files
------------

// File: rtl/datagen_pkg.sv
// Shared types and constants for the frame capture/stream generator.
package datagen_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DELAY  = 3'd1,
        S_SAMPLE = 3'd2,
        S_LOAD   = 3'd3,
        S_STREAM = 3'd4
    } state_t;

    localparam logic [1:0] MODE_CTR  = 2'd0;
    localparam logic [1:0] MODE_LFSR = 2'd1;
    localparam logic [1:0] MODE_PAT  = 2'd2;

    // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
    localparam logic [31:0] LFSR_POLY = 32'h80200003;

    // An all-zero register is a lock-up state, so it reloads the seed instead.
    function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
        logic [31:0] nxt;
        if (cur == 32'd0) begin
            nxt = 32'd1;
        end else begin
            nxt = (cur >> 1) ^ (cur[0] ? LFSR_POLY : 32'd0);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/datagen_stream_if.sv
// AXI4-Stream channel carrying generated frames toward the DMA write path.
interface datagen_stream_if #(
    parameter int DATA_W = 32
);
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [DATA_W-1:0] tdata;

    modport master (output tvalid, output tlast, output tdata, input tready);
    modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/datagen_stream_sample_ram.sv
// Frame buffer: one write port, one registered read port.
module sample_ram #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_W-1:0]     rd_data
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
    logic [DATA_W-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the output register is cleared; it doubles as the stream data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/datagen_stream.sv
// Captures a frame of counter/LFSR/pattern samples, then replays it as an AXI4-Stream frame.
module datagen_stream
    import datagen_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_ctr,
    input  logic                  en_sample,
    input  logic [1:0]            mode,
    input  logic [DATA_W-1:0]     pattern,
    input  logic                  one_shot,
    input  logic [DEPTH_LOG2:0]   frame_size,
    input  logic [7:0]            decim,
    input  logic [31:0]           delay,
    input  logic                  clr,
    output logic                  done,
    output logic [15:0]           frame_cnt,
    output logic [2:0]            debug_state,
    datagen_stream_if.master      m_axis
);

    localparam logic [DEPTH_LOG2:0] FRAME_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};

    state_t                  state_reg;
    state_t                  state_next;
    logic [DATA_W-1:0]       ctr_reg;
    logic [31:0]             lfsr_reg;
    logic [31:0]             delay_ctr_reg;
    logic [7:0]              decim_ctr_reg;
    logic [DEPTH_LOG2-1:0]   wr_ptr_reg;
    logic [DEPTH_LOG2-1:0]   rd_ptr_reg;
    logic [DEPTH_LOG2-1:0]   last_idx_reg;
    logic [DEPTH_LOG2-1:0]   last_idx_next;
    logic                    done_reg;
    logic [15:0]             frame_cnt_reg;

    logic [DATA_W-1:0]       sample_val;
    logic                    stream_active;
    logic                    handshake;
    logic                    is_last;
    logic                    write_hit;
    logic                    write_last;
    logic                    frame_end;
    logic                    wr_en;
    logic                    rd_en;
    logic [DEPTH_LOG2-1:0]   rd_addr;
    logic [DATA_W-1:0]       ram_rd_data;

    // Frames are tracked by index of the last sample, so 0 and oversize clamp here.
    always_comb begin
        last_idx_next = DEPTH_LOG2'(frame_size - 1'b1);
        if (frame_size == '0) begin
            last_idx_next = '0;
        end else if (frame_size > FRAME_MAX) begin
            last_idx_next = '1;
        end
    end

    always_comb begin
        case (mode)
            MODE_LFSR: sample_val = lfsr_reg[DATA_W-1:0];
            MODE_PAT:  sample_val = pattern;
            default:   sample_val = ctr_reg;
        endcase
    end

    assign stream_active = (state_reg == S_STREAM);
    assign handshake     = stream_active & m_axis.tready;
    assign is_last       = (rd_ptr_reg == last_idx_reg);
    assign write_hit     = (decim_ctr_reg == 8'd0);
    assign write_last    = write_hit && (wr_ptr_reg == last_idx_reg);
    assign frame_end     = handshake && is_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (en_sample) state_next = S_DELAY;
            end
            S_DELAY: begin
                if (!en_sample)              state_next = S_IDLE;
                else if (delay_ctr_reg == delay) state_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (!en_sample)      state_next = S_IDLE;
                else if (write_last) state_next = S_LOAD;
            end
            S_LOAD: begin
                state_next = S_STREAM;
            end
            S_STREAM: begin
                // Dropping en_sample only matters once the current frame has finished.
                if (frame_end) state_next = (one_shot || !en_sample) ? S_IDLE : S_DELAY;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        m_axis.tvalid = stream_active;
        m_axis.tlast  = stream_active && is_last;
        wr_en         = (state_reg == S_SAMPLE) && en_sample && write_hit;
        rd_en         = (state_reg == S_LOAD) || (handshake && !is_last);
        rd_addr       = (state_reg == S_LOAD) ? '0 : rd_ptr_reg + DEPTH_LOG2'(1);
        debug_state   = state_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctr_reg       <= '0;
            lfsr_reg      <= 32'd1;
            delay_ctr_reg <= '0;
            decim_ctr_reg <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            last_idx_reg  <= '0;
            done_reg      <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            if (en_ctr) begin
                ctr_reg  <= ctr_reg + DATA_W'(1);
                lfsr_reg <= lfsr_step(lfsr_reg);
            end

            delay_ctr_reg <= (state_reg == S_DELAY) ? delay_ctr_reg + 32'd1 : 32'd0;

            if (state_reg == S_SAMPLE) begin
                decim_ctr_reg <= (decim_ctr_reg == decim) ? 8'd0 : decim_ctr_reg + 8'd1;
                if (wr_en) wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
            end else begin
                decim_ctr_reg <= '0;
                wr_ptr_reg    <= '0;
            end

            if (state_reg == S_DELAY && state_next == S_SAMPLE) begin
                last_idx_reg <= last_idx_next;
            end

            if (!stream_active) begin
                rd_ptr_reg <= '0;
            end else if (handshake) begin
                rd_ptr_reg <= rd_ptr_reg + DEPTH_LOG2'(1);
            end

            // A completing frame outranks a simultaneous clear.
            if (frame_end) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
                done_reg      <= 1'b1;
            end else if (clr) begin
                done_reg      <= 1'b0;
            end
        end
    end

    sample_ram #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_reg),
        .wr_data (sample_val),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

    assign m_axis.tdata = ram_rd_data;
    assign done         = done_reg;
    assign frame_cnt    = frame_cnt_reg;

endmodule
